// File: rtl/mgmt_regs_pkg.sv
// Shared register map, field positions and helpers for the per-port management register bank.
package mgmt_regs_pkg;

  localparam int unsigned VLAN_BITS     = 12;
  localparam int unsigned TAG_MODE_BITS = 5;

  // TAG_MODE bit indices
  localparam int unsigned TAGGED_IN      = 0;
  localparam int unsigned UNTAGGED_IN    = 1;
  localparam int unsigned TAG_NATIVE_OUT = 2;
  localparam int unsigned TAG_OTHER_OUT  = 3;
  localparam int unsigned TRUNK          = 4;

  localparam logic [TAG_MODE_BITS-1:0] TAG_MODE_MASK = TAG_MODE_BITS'(
      (1 << TAGGED_IN) | (1 << UNTAGGED_IN) | (1 << TAG_NATIVE_OUT) |
      (1 << TAG_OTHER_OUT) | (1 << TRUNK));

  // STATUS byte layout
  localparam int unsigned STATUS_LINK_BIT   = 0;
  localparam int unsigned STATUS_SPEED_LSB  = 1;
  localparam int unsigned STATUS_SPEED_BITS = 2;

  typedef enum logic [7:0] {
    RegVlanLo  = 8'h00,
    RegVlanHi  = 8'h01,
    RegTagMode = 8'h02,
    RegStatus  = 8'h03,
    RegRxB0    = 8'h10,
    RegRxB1    = 8'h11,
    RegRxB2    = 8'h12,
    RegRxB3    = 8'h13,
    RegDropB0  = 8'h14,
    RegDropB1  = 8'h15,
    RegDropB2  = 8'h16,
    RegDropB3  = 8'h17,
    RegCtrCtrl = 8'h18,
    RegNone    = 8'hFF  // decode result for register ids beyond one byte
  } portreg_t;

  function automatic logic [7:0] status_byte(input logic link_up,
                                             input logic [STATUS_SPEED_BITS-1:0] speed);
    logic [7:0] s;
    s = '0;
    s[STATUS_LINK_BIT] = link_up;
    s[STATUS_SPEED_LSB +: STATUS_SPEED_BITS] = speed;
    return s;
  endfunction

endpackage

// File: rtl/mgmt_sat_counter.sv
// 32-bit saturating event counter with priority clear and a read-triggered snapshot register.
module mgmt_sat_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        clr,
  input  logic        snap,
  output logic [31:0] live,
  output logic [31:0] snapshot
);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] snap_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Snapshot captures the pre-increment value, matching the byte returned by the same read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      snap_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (snap) snap_q <= cnt_q;
    end
  end

  assign live     = cnt_q;
  assign snapshot = snap_q;

endmodule

// File: rtl/mgmt_port_regfile.sv
// Per-port configuration and statistics register bank on the 8-bit management bus.
module mgmt_port_regfile
  import mgmt_regs_pkg::*;
#(
  parameter int unsigned NUM_PORTS       = 15,
  parameter int unsigned PORT_BITS       = 4,
  parameter int unsigned REGID_BITS      = 10,
  parameter logic [15:0] BASE_ADDR       = 16'h4000,
  parameter logic [11:0] DEFAULT_VLAN    = 12'd1,
  parameter logic [4:0]  DEFAULT_TAGMODE = 5'b00010
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           rd_en,
  input  logic [15:0]                    rd_addr,
  output logic                           rd_valid,
  output logic [7:0]                     rd_data,
  output logic                           rd_err,
  input  logic                           wr_en,
  input  logic [15:0]                    wr_addr,
  input  logic [7:0]                     wr_data,
  output logic                           wr_err,
  output logic [NUM_PORTS*12-1:0]        port_vlan,
  output logic [NUM_PORTS*5-1:0]         port_tag_mode,
  output logic [NUM_PORTS-1:0]           port_cfg_updated,
  input  logic [NUM_PORTS-1:0]           port_link_up,
  input  logic [NUM_PORTS*2-1:0]         port_speed,
  input  logic [NUM_PORTS-1:0]           port_rx_frame,
  input  logic [NUM_PORTS-1:0]           port_drop_frame
);

  localparam int unsigned SPAN_BITS = PORT_BITS + REGID_BITS;

  logic [VLAN_BITS-1:0]     vlan_q  [NUM_PORTS];
  logic [7:0]               stage_q [NUM_PORTS];
  logic [TAG_MODE_BITS-1:0] tag_q   [NUM_PORTS];
  logic [NUM_PORTS-1:0]     cfg_upd_q;

  logic [31:0] rx_live   [NUM_PORTS];
  logic [31:0] rx_snap   [NUM_PORTS];
  logic [31:0] drop_live [NUM_PORTS];
  logic [31:0] drop_snap [NUM_PORTS];

  logic [NUM_PORTS-1:0] stage_we, vlan_commit, tag_commit, ctr_clr;
  logic [NUM_PORTS-1:0] rx_snap_en, drop_snap_en;

  logic       rd_valid_q, rd_err_q, rd_err_d, wr_err_q, wr_err_d;
  logic [7:0] rd_data_q, rd_data_d;

  // Read-side decode
  logic [15:0]           rd_off;
  logic [PORT_BITS-1:0]  rd_port, rd_pidx;
  logic [REGID_BITS-1:0] rd_regid;
  logic [31:0]           rd_rid32;
  logic                  rd_in_range;
  portreg_t              rd_reg;

  assign rd_off      = rd_addr - BASE_ADDR;
  assign rd_port     = rd_off[REGID_BITS +: PORT_BITS];
  assign rd_regid    = rd_off[REGID_BITS-1:0];
  assign rd_rid32    = 32'(rd_regid);
  assign rd_in_range = (rd_addr >= BASE_ADDR) && ((32'(rd_off) >> SPAN_BITS) == 32'd0) &&
                       (32'(rd_port) < NUM_PORTS);
  assign rd_pidx     = rd_in_range ? rd_port : '0;
  assign rd_reg      = (rd_rid32 < 32'd256) ? portreg_t'(rd_rid32[7:0]) : RegNone;

  // Write-side decode
  logic [15:0]           wr_off;
  logic [PORT_BITS-1:0]  wr_port, wr_pidx;
  logic [REGID_BITS-1:0] wr_regid;
  logic [31:0]           wr_rid32;
  logic                  wr_in_range;
  portreg_t              wr_reg;

  assign wr_off      = wr_addr - BASE_ADDR;
  assign wr_port     = wr_off[REGID_BITS +: PORT_BITS];
  assign wr_regid    = wr_off[REGID_BITS-1:0];
  assign wr_rid32    = 32'(wr_regid);
  assign wr_in_range = (wr_addr >= BASE_ADDR) && ((32'(wr_off) >> SPAN_BITS) == 32'd0) &&
                       (32'(wr_port) < NUM_PORTS);
  assign wr_pidx     = wr_in_range ? wr_port : '0;
  assign wr_reg      = (wr_rid32 < 32'd256) ? portreg_t'(wr_rid32[7:0]) : RegNone;

  // Read data is formed from current state, so a same-cycle write is not visible yet.
  always_comb begin
    rd_data_d    = '0;
    rd_err_d     = 1'b1;
    rx_snap_en   = '0;
    drop_snap_en = '0;
    if (rd_in_range) begin
      rd_err_d = 1'b0;
      case (rd_reg)
        RegVlanLo:  rd_data_d = vlan_q[rd_pidx][7:0];
        RegVlanHi:  rd_data_d = {4'b0, vlan_q[rd_pidx][11:8]};
        RegTagMode: rd_data_d = {3'b0, tag_q[rd_pidx]};
        RegStatus:  rd_data_d = status_byte(port_link_up[rd_pidx], port_speed[2*rd_pidx +: 2]);
        RegRxB0: begin
          rd_data_d           = rx_live[rd_pidx][7:0];
          rx_snap_en[rd_pidx] = rd_en;
        end
        RegRxB1:    rd_data_d = rx_snap[rd_pidx][15:8];
        RegRxB2:    rd_data_d = rx_snap[rd_pidx][23:16];
        RegRxB3:    rd_data_d = rx_snap[rd_pidx][31:24];
        RegDropB0: begin
          rd_data_d             = drop_live[rd_pidx][7:0];
          drop_snap_en[rd_pidx] = rd_en;
        end
        RegDropB1:  rd_data_d = drop_snap[rd_pidx][15:8];
        RegDropB2:  rd_data_d = drop_snap[rd_pidx][23:16];
        RegDropB3:  rd_data_d = drop_snap[rd_pidx][31:24];
        RegCtrCtrl: rd_data_d = '0;
        default:    rd_err_d  = 1'b1;
      endcase
    end
  end

  always_comb begin
    stage_we    = '0;
    vlan_commit = '0;
    tag_commit  = '0;
    ctr_clr     = '0;
    wr_err_d    = 1'b0;
    if (wr_en) begin
      if (!wr_in_range) begin
        wr_err_d = 1'b1;
      end else begin
        case (wr_reg)
          RegVlanLo:  stage_we[wr_pidx]    = 1'b1;
          RegVlanHi:  vlan_commit[wr_pidx] = 1'b1;
          RegTagMode: tag_commit[wr_pidx]  = 1'b1;
          RegCtrCtrl: ctr_clr[wr_pidx]     = wr_data[0];
          default:    wr_err_d             = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        vlan_q[p]  <= DEFAULT_VLAN;
        stage_q[p] <= '0;
        tag_q[p]   <= DEFAULT_TAGMODE;
      end
      cfg_upd_q <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (stage_we[p])    stage_q[p] <= wr_data;
        if (vlan_commit[p]) vlan_q[p]  <= {wr_data[3:0], stage_q[p]};
        if (tag_commit[p])  tag_q[p]   <= wr_data[TAG_MODE_BITS-1:0] & TAG_MODE_MASK;
      end
      cfg_upd_q <= vlan_commit | tag_commit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      rd_data_q  <= rd_en ? rd_data_d : '0;
      rd_err_q   <= rd_en & rd_err_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign rd_valid         = rd_valid_q;
  assign rd_data          = rd_data_q;
  assign rd_err           = rd_err_q;
  assign wr_err           = wr_err_q;
  assign port_cfg_updated = cfg_upd_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : gen_port
    assign port_vlan[p*VLAN_BITS +: VLAN_BITS]             = vlan_q[p];
    assign port_tag_mode[p*TAG_MODE_BITS +: TAG_MODE_BITS] = tag_q[p];

    mgmt_sat_counter u_rx_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (port_rx_frame[p]),
      .clr      (ctr_clr[p]),
      .snap     (rx_snap_en[p]),
      .live     (rx_live[p]),
      .snapshot (rx_snap[p])
    );

    mgmt_sat_counter u_drop_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (port_drop_frame[p]),
      .clr      (ctr_clr[p]),
      .snap     (drop_snap_en[p]),
      .live     (drop_live[p]),
      .snapshot (drop_snap[p])
    );
  end

endmodule

// File: tb/tb_mgmt_port_regfile.sv
// Scoreboard bench for mgmt_port_regfile: a register-map model predicts every read, write error
// and config-update pulse; a monitor compares them as the DUT presents them.
module tb_mgmt_port_regfile;

  localparam int NP = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rd_en, wr_en;
  logic [15:0]       rd_addr, wr_addr;
  logic [7:0]        wr_data;
  logic              rd_valid, rd_err, wr_err;
  logic [7:0]        rd_data;
  logic [NP*12-1:0]  port_vlan;
  logic [NP*5-1:0]   port_tag_mode;
  logic [NP-1:0]     port_cfg_updated;
  logic [NP-1:0]     port_link_up, port_rx_frame, port_drop_frame;
  logic [NP*2-1:0]   port_speed;

  logic [NP-1:0]     nx_link;
  logic [NP*2-1:0]   nx_speed;

  mgmt_port_regfile dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rd_en            (rd_en),
    .rd_addr          (rd_addr),
    .rd_valid         (rd_valid),
    .rd_data          (rd_data),
    .rd_err           (rd_err),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .wr_err           (wr_err),
    .port_vlan        (port_vlan),
    .port_tag_mode    (port_tag_mode),
    .port_cfg_updated (port_cfg_updated),
    .port_link_up     (port_link_up),
    .port_speed       (port_speed),
    .port_rx_frame    (port_rx_frame),
    .port_drop_frame  (port_drop_frame)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: plain per-port state following the register map rules
  logic [11:0] m_vlan  [NP];
  logic [7:0]  m_stage [NP];
  logic [4:0]  m_tag   [NP];
  logic [31:0] m_rx [NP], m_rx_snap [NP], m_drop [NP], m_drop_snap [NP];

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_vlan[p] = 12'd1; m_stage[p] = '0; m_tag[p] = 5'b00010;
      m_rx[p] = '0; m_rx_snap[p] = '0; m_drop[p] = '0; m_drop_snap[p] = '0;
    end
  endtask

  function automatic void decode(input logic [15:0] a, output bit ok, output int p,
                                 output int r);
    int off;
    off = int'(a) - 'h4000;
    p   = off / 1024;
    r   = off % 1024;
    ok  = (a >= 16'h4000) && (p < NP);
  endfunction

  function automatic void model_read(input logic [15:0] a, output logic [7:0] d,
                                     output logic e);
    bit ok; int p, r;
    decode(a, ok, p, r);
    d = '0; e = 1'b0;
    if (!ok) begin e = 1'b1; return; end
    case (r)
      'h00: d = m_vlan[p][7:0];
      'h01: d = 8'(m_vlan[p] / 256);
      'h02: d = 8'(m_tag[p]);
      'h03: d = 8'(port_speed[2*p +: 2] * 2 + port_link_up[p]);
      'h10: begin d = 8'(m_rx[p] % 256); m_rx_snap[p] = m_rx[p]; end
      'h11, 'h12, 'h13: d = 8'(m_rx_snap[p] >> (8 * (r - 'h10)));
      'h14: begin d = 8'(m_drop[p] % 256); m_drop_snap[p] = m_drop[p]; end
      'h15, 'h16, 'h17: d = 8'(m_drop_snap[p] >> (8 * (r - 'h14)));
      'h18: d = '0;
      default: e = 1'b1;
    endcase
  endfunction

  function automatic void model_write(input logic [15:0] a, input logic [7:0] w, output bit err,
                                      output logic [NP-1:0] upd, output logic [NP-1:0] clr);
    bit ok; int p, r;
    decode(a, ok, p, r);
    err = 1'b0; upd = '0; clr = '0;
    if (!ok) begin err = 1'b1; return; end
    case (r)
      'h00: m_stage[p] = w;
      'h01: begin m_vlan[p] = 12'((w % 16) * 256 + m_stage[p]); upd[p] = 1'b1; end
      'h02: begin m_tag[p] = 5'(w % 32); upd[p] = 1'b1; end
      'h18: clr[p] = w[0];
      default: err = 1'b1;
    endcase
  endfunction

  typedef struct { int due; logic [7:0] data; logic err; } rd_exp_t;
  typedef struct { int due; logic [NP-1:0] vec; } upd_exp_t;
  rd_exp_t  rd_q[$];
  int       werr_q[$];
  upd_exp_t upd_q[$];

  // One bus cycle: drive at the falling edge, predict, and update the model in bus order
  task automatic step(input logic r_en, input logic [15:0] r_a, input logic w_en,
                      input logic [15:0] w_a, input logic [7:0] w_d, input logic [NP-1:0] rx,
                      input logic [NP-1:0] dr);
    logic [7:0] d; logic e; bit werr; logic [NP-1:0] upd, clr;
    @(negedge clk);
    rd_en = r_en; rd_addr = r_a; wr_en = w_en; wr_addr = w_a; wr_data = w_d;
    port_rx_frame = rx; port_drop_frame = dr;
    port_link_up = nx_link; port_speed = nx_speed;
    if (r_en) begin
      model_read(r_a, d, e);
      rd_q.push_back('{cyc + 1, d, e});
    end
    werr = 1'b0; upd = '0; clr = '0;
    if (w_en) model_write(w_a, w_d, werr, upd, clr);
    if (werr) werr_q.push_back(cyc + 1);
    if (upd != '0) upd_q.push_back('{cyc + 1, upd});
    for (int p = 0; p < NP; p++) begin
      if (clr[p]) begin
        m_rx[p] = '0; m_drop[p] = '0;
      end else begin
        if (rx[p] && m_rx[p] != 32'hFFFF_FFFF) m_rx[p] = m_rx[p] + 1;
        if (dr[p] && m_drop[p] != 32'hFFFF_FFFF) m_drop[p] = m_drop[p] + 1;
      end
    end
  endtask

  task automatic rd(input logic [15:0] a);
    step(1'b1, a, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] w);
    step(1'b0, '0, 1'b1, a, w, '0, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic check_cfg();
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("port_vlan[%0d]", p), 32'(port_vlan[p*12 +: 12]), 32'(m_vlan[p]));
      chk($sformatf("port_tag_mode[%0d]", p), 32'(port_tag_mode[p*5 +: 5]), 32'(m_tag[p]));
    end
  endtask

  function automatic logic [15:0] rand_addr();
    int k, p, r;
    k = $urandom_range(0, 15);
    if (k == 0) return 16'($urandom);
    p = $urandom_range(0, 15);
    case (k)
      1: r = 'h00; 2: r = 'h01; 3: r = 'h02; 4: r = 'h03;
      5: r = 'h10; 6: r = 'h11; 7: r = 'h12; 8: r = 'h13;
      9: r = 'h14; 10: r = 'h15; 11: r = 'h16; 12: r = 'h17;
      13: r = 'h18; 14: r = 'h19;
      default: r = 'h3FF;
    endcase
    return 16'('h4000 + p * 1024 + r);
  endfunction

  // Monitor: compare every presented output against the scoreboard queues
  always @(negedge clk) begin : monitor
    rd_exp_t  re;
    upd_exp_t ue;
    logic     exp_werr;
    logic [NP-1:0] exp_upd;
    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      re = rd_q.pop_front();
      chk("rd_valid", 32'(rd_valid), 32'd1);
      chk("rd_data", 32'(rd_data), 32'(re.data));
      chk("rd_err", 32'(rd_err), 32'(re.err));
    end else if (rd_valid) begin
      chk("rd_valid_unexpected", 32'(rd_valid), 32'd0);
    end
    exp_werr = 1'b0;
    if (werr_q.size() > 0 && werr_q[0] == cyc) begin
      exp_werr = 1'b1;
      void'(werr_q.pop_front());
    end
    if (exp_werr || wr_err) chk("wr_err", 32'(wr_err), 32'(exp_werr));
    exp_upd = '0;
    if (upd_q.size() > 0 && upd_q[0].due == cyc) begin
      ue = upd_q.pop_front();
      exp_upd = ue.vec;
    end
    if (exp_upd != '0 || port_cfg_updated != '0)
      chk("port_cfg_updated", 32'(port_cfg_updated), 32'(exp_upd));
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    port_rx_frame = '0; port_drop_frame = '0;
    nx_link = '0; nx_speed = '0; port_link_up = '0; port_speed = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    chk("reset_rd_err", 32'(rd_err), 32'd0);
    chk("reset_wr_err", 32'(wr_err), 32'd0);
    chk("reset_cfg_updated", 32'(port_cfg_updated), 32'd0);
    rst_n = 1'b1;
    check_cfg();

    // Reset values via the bus, back-to-back
    rd(16'h4000); rd(16'h4001); rd(16'h4002);

    // VLAN staging and commit on port 1
    wr(16'h4400, 8'h34);
    rd(16'h4400);
    wr(16'h4401, 8'hA2);
    rd(16'h4400); rd(16'h4401);
    check_cfg();

    // Same-address read/write returns old value; TAG_MODE upper bits dropped
    step(1'b1, 16'h4002, 1'b1, 16'h4002, 8'hE5, '0, '0);
    rd(16'h4002);
    // Different addresses in the same cycle
    step(1'b1, 16'h4401, 1'b1, 16'h4C02, 8'h1B, '0, '0);
    rd(16'h4C02);
    check_cfg();

    // Saturation: preload port 2 RX counter just below the ceiling
    idle(1);
    @(negedge clk);
    force dut.gen_port[2].u_rx_ctr.cnt_d = 32'hFFFF_FFFE;
    @(posedge clk);
    #1 release dut.gen_port[2].u_rx_ctr.cnt_d;
    m_rx[2] = 32'hFFFF_FFFE;
    repeat (3) step(1'b0, '0, 1'b0, '0, '0, 15'h0004, '0);
    rd(16'h4810); rd(16'h4811); rd(16'h4812); rd(16'h4813);

    // Clear, then snapshot behaviour
    step(1'b0, '0, 1'b1, 16'h4818, 8'h01, 15'h0004, '0);
    rd(16'h4810);
    repeat (261) step(1'b0, '0, 1'b0, '0, '0, 15'h0004, '0);
    rd(16'h4810);
    repeat (4) step(1'b0, '0, 1'b0, '0, '0, 15'h0004, '0);
    rd(16'h4811); rd(16'h4810);
    step(1'b0, '0, 1'b1, 16'h4818, 8'h01, 15'h0004, '0);
    rd(16'h4811); rd(16'h4812); rd(16'h4810);
    step(1'b1, 16'h4818, 1'b0, '0, '0, '0, '0);

    // Drop counter on port 5, with a read during increment
    repeat (7) step(1'b0, '0, 1'b0, '0, '0, '0, 15'h0020);
    step(1'b1, 16'h5414, 1'b0, '0, '0, '0, 15'h0020);
    rd(16'h5414); rd(16'h5415);

    // Unmapped and read-only accesses
    nx_link = 15'h0001; nx_speed = 30'h2;
    rd(16'h3C00); rd(16'h7C00); rd(16'h4019); rd(16'hFFFF);
    wr(16'h4003, 8'hFF);
    wr(16'h4812, 8'h55);
    wr(16'h7C01, 8'h01);
    rd(16'h4003);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      logic r_en, w_en;
      logic [15:0] w_a;
      if ($urandom_range(0, 7) == 0) begin
        nx_link  = NP'($urandom);
        nx_speed = (NP*2)'($urandom);
      end
      r_en = ($urandom_range(0, 1) == 1);
      w_en = ($urandom_range(0, 2) == 0);
      w_a  = rand_addr();
      step(r_en, rand_addr(), w_en, w_a, 8'($urandom), NP'($urandom), NP'($urandom));
      if (i % 100 == 99) check_cfg();
    end

    // Reset asserted while a read is in flight: the read is dropped
    idle(3);
    @(negedge clk);
    rd_en = 1'b1; rd_addr = 16'h4000;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 chk("rd_valid_during_reset", 32'(rd_valid), 32'd0);
    @(negedge clk);
    chk("rd_valid_after_reset_edge", 32'(rd_valid), 32'd0);
    rd_en = 1'b0;
    rst_n = 1'b1;
    model_reset();
    check_cfg();
    rd(16'h4000); rd(16'h4002); rd(16'h4810);

    idle(4);
    chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    chk("wr_err_queue_drained", 32'(werr_q.size()), 32'd0);
    chk("upd_queue_drained", 32'(upd_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mgmt_port_regfile.md
Name: mgmt_port_regfile

Overview:
- Parametrised per-port configuration and statistics register bank behind the management QSPI/sim bridge bus (8-bit data, 16-bit address).
- Next generation of the port-config decode: adds full readback, atomic multi-byte commit, read-only status, and per-port saturating frame counters with snapshot reads.
- Sits in the management clock domain. Its outputs feed the existing per-port RX-domain register synchronizers.

Parameters:
- NUM_PORTS, 15, number of switch ports decoded (1..16).
- PORT_BITS, 4, address bits selecting the port.
- REGID_BITS, 10, address bits selecting a register within a port block (stride = 2^REGID_BITS).
- BASE_ADDR, 16'h4000, first address of port 0's block.
- DEFAULT_VLAN, 12'd1, reset VLAN for every port.
- DEFAULT_TAGMODE, 5'b00010, reset TAG_MODE (untagged inbound allowed only).

Ports:
- clk  in  1  management core clock
- rst_n  in  1  asynchronous active-low reset
- rd_en  in  1  read request strobe
- rd_addr  in  16  read address
- rd_valid  out  1  read data valid, one-cycle pulse
- rd_data  out  8  read data
- rd_err  out  1  pulses with rd_valid when the address is unmapped
- wr_en  in  1  write strobe
- wr_addr  in  16  write address
- wr_data  in  8  write data
- wr_err  out  1  one-cycle pulse, cycle after a write to an unmapped or read-only address
- port_vlan  out  NUM_PORTS*12  committed native VLAN per port
- port_tag_mode  out  NUM_PORTS*5  committed TAG_MODE per port
- port_cfg_updated  out  NUM_PORTS  one-cycle pulse per port when VLAN or TAG_MODE commits
- port_link_up  in  NUM_PORTS  link status, core domain
- port_speed  in  NUM_PORTS*2  link speed code, core domain
- port_rx_frame  in  NUM_PORTS  one-cycle increment strobe, received frames
- port_drop_frame  in  NUM_PORTS  one-cycle increment strobe, dropped frames

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Address decode: off = addr - BASE_ADDR; port = off[REGID_BITS +: PORT_BITS]; regid = off[REGID_BITS-1:0].
  - Unmapped if addr < BASE_ADDR, port >= NUM_PORTS, off >= 2^(PORT_BITS+REGID_BITS), or regid not in the map.
- Per-port map (multi-byte registers are little endian):
  - 0x00 VLAN_LO (RW, staged)
  - 0x01 VLAN_HI (RW, [3:0] used, commit)
  - 0x02 TAG_MODE (RW, [4:0])
  - 0x03 STATUS (RO: {5'b0, speed[1:0], link_up})
  - 0x10-0x13 RX_FRAMES (RO)
  - 0x14-0x17 DROP_FRAMES (RO)
  - 0x18 CTR_CTRL (WO: bit0 = clear both counters; reads as 0)
- Read latency: fixed 1 cycle. rd_en in cycle N gives rd_valid=1 with rd_data in N+1. No wait states, no back-pressure.
  - rd_en on consecutive cycles returns back-to-back results.
- Unmapped read: rd_data=0, rd_valid=1, rd_err=1.
- VLAN staging: a write to 0x00 loads a per-port staging byte only.
  - A write to 0x01 commits {wr_data[3:0], staging} to port_vlan and pulses port_cfg_updated next cycle.
  - Reads of 0x00/0x01 return the committed VLAN, never the staging byte. Read 0x01 returns {4'b0, vlan[11:8]}.
- TAG_MODE write: commits wr_data[4:0] immediately and pulses port_cfg_updated. Bits [7:5] are ignored and read back as 0.
- Counters: 32-bit per port per type, increment on strobe, saturate at 32'hFFFFFFFF with no wrap.
  - Clear (CTR_CTRL bit0=1) and a same-cycle increment: clear wins, result 0.
- Snapshot: a read of byte 0 (0x10 / 0x14) returns live[7:0] and latches the full live value into that counter's 32-bit snapshot.
  - Bytes 1..3 return snapshot bytes. A clear does not alter the snapshot.
- Same-cycle read and write to the same address: the read returns the pre-write value. Different addresses: both are serviced.
- Write to STATUS or a counter byte: ignored, wr_err pulse.
- Reset values:
  - rd_valid, rd_data, rd_err, wr_err, port_cfg_updated: 0.
  - port_vlan: DEFAULT_VLAN. port_tag_mode: DEFAULT_TAGMODE.
  - Counters, snapshots and staging bytes: 0.
- Reset asserted mid-read: rd_valid stays 0 and the read is dropped.

Decomposition:
- Package mgmt_regs_pkg holds:
  - the per-port offset enum (portreg_t)
  - TAG_MODE bit indices (TAGGED_IN=0, UNTAGGED_IN=1, TAG_NATIVE_OUT=2, TAG_OTHER_OUT=3, TRUNK=4)
  - VLAN_BITS=12 and the STATUS field positions
- Sub-module mgmt_sat_counter: 32-bit saturating counter with inc, clr, snap inputs and live/snapshot outputs. Instantiated 2*NUM_PORTS times.

Test Plan:
- Reset, then read 0x4000/0x4001/0x4002 on port 0 -> 0x01, 0x00, 0x02, each rd_valid exactly 1 cycle after rd_en, rd_err=0.
- Write 0x4400=0x34, then read 0x4400 -> 0x01 (staged only). Write 0x4401=0xA2 -> port_vlan[1]=12'h234, port_cfg_updated[1] single pulse. Read 0x4400/0x4401 -> 0x34/0x02.
- Preload port 2 RX counter to 32'hFFFFFFFE, pulse port_rx_frame[2] 3 times, read 0x4810..0x4813 -> FF FF FF FF (saturated).
- Read 0x4810 with counter=0x00000105, then 4 increments, then read 0x4811 -> 0x01 (snapshot). Live value is 0x109.
- Write 0x4818=0x01 in the same cycle as port_rx_frame[2]=1 -> counter 0. Snapshot is unchanged.
- Read 0x3C00 and 0x7C00 (port 15, NUM_PORTS=15) -> rd_data=0, rd_err=1. Write 0x4003 -> wr_err pulse, STATUS unchanged.
